// File: rtl/hes_msg_feeder.sv
// Byte feeder for AES_Stream_Cipher: buffers host bytes in a FIFO and presents them
// on a registered output slot, latching the cipher key only at message boundaries.
module hes_msg_feeder #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  input  logic             s_sof,
  input  logic             key_wr,
  input  logic [7:0]       key_wr_data,
  input  logic             c_ready,
  output logic             c_valid,
  output logic             c_new_message,
  output logic [7:0]       c_key,
  output logic [7:0]       c_data,
  output logic             busy,
  output logic [CNT_W-1:0] msg_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic {
    NO_MSG,
    IN_MSG
  } state_t;

  state_t           state_q, state_d;
  logic [8:0]       mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [7:0]       key_shadow_q, key_shadow_d;
  logic             c_valid_q, c_valid_d;
  logic             c_new_message_q, c_new_message_d;
  logic [7:0]       c_key_q, c_key_d;
  logic [7:0]       c_data_q, c_data_d;
  logic [CNT_W-1:0] msg_count_q, msg_count_d;

  logic       fifo_full, fifo_empty;
  logic       push, pop, msg_start;
  logic [8:0] head;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head       = mem_q[rd_ptr_q[AW-1:0]];

  assign push      = s_valid && !fifo_full;
  assign pop       = !fifo_empty && (!c_valid_q || c_ready);
  assign msg_start = pop && (head[8] || (state_q == NO_MSG));

  always_comb begin
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    state_d         = state_q;
    key_shadow_d    = key_shadow_q;
    c_valid_d       = c_valid_q;
    c_new_message_d = c_new_message_q;
    c_key_d         = c_key_q;
    c_data_d        = c_data_q;
    msg_count_d     = msg_count_q;

    if (push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    if (key_wr) key_shadow_d = key_wr_data;

    if (pop) begin
      c_valid_d       = 1'b1;
      c_data_d        = head[7:0];
      c_new_message_d = msg_start;
      if (msg_start) begin
        // Pre-write shadow value: a same-cycle key_wr applies to the next message.
        c_key_d     = key_shadow_q;
        msg_count_d = msg_count_q + CNT_W'(1);
        state_d     = IN_MSG;
      end
    end else if (c_ready) begin
      c_valid_d       = 1'b0;
      c_new_message_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= NO_MSG;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      key_shadow_q    <= '0;
      c_valid_q       <= 1'b0;
      c_new_message_q <= 1'b0;
      c_key_q         <= '0;
      c_data_q        <= '0;
      msg_count_q     <= '0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      key_shadow_q    <= key_shadow_d;
      c_valid_q       <= c_valid_d;
      c_new_message_q <= c_new_message_d;
      c_key_q         <= c_key_d;
      c_data_q        <= c_data_d;
      msg_count_q     <= msg_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {s_sof, s_data};
  end

  assign s_ready       = !fifo_full;
  assign busy          = !fifo_empty || c_valid_q;
  assign c_valid       = c_valid_q;
  assign c_new_message = c_new_message_q;
  assign c_key         = c_key_q;
  assign c_data        = c_data_q;
  assign msg_count     = msg_count_q;

endmodule

// File: doc/hes_msg_feeder.md
Name: hes_msg_feeder

Overview:
Upstream feeder for AES_Stream_Cipher.
- Accepts plaintext bytes from a host-side valid/ready stream, where a start-of-message flag marks the first byte of each message.
- Buffers the bytes in a FIFO and drives the cipher's byte interface: valid, new_message, key, data.
- Keeps the cipher key stable for the whole duration of each message. Key updates take effect only at a message boundary.

Parameters:
DEPTH, 16, FIFO entries (power of 2, >=2); each entry stores {sof, data[7:0]}.
CNT_W, 8, width of the msg_count counter.

Ports:
clk  in  1  clock; all logic is on the rising edge.
reset  in  1  synchronous, active-high reset.
s_valid  in  1  host byte valid.
s_ready  out  1  feeder can accept a byte.
s_data  in  8  host plaintext byte.
s_sof  in  1  byte is the first byte of a new message.
key_wr  in  1  write key_wr_data to the key shadow register.
key_wr_data  in  8  new key value.
c_ready  in  1  downstream accept; tie to 1 for AES_Stream_Cipher.
c_valid  out  1  to cipher valid_in.
c_new_message  out  1  to cipher new_message.
c_key  out  8  to cipher key.
c_data  out  8  to cipher data_in.
busy  out  1  FIFO not empty, or c_valid is high.
msg_count  out  CNT_W  number of messages started since reset; wraps.

Behaviour:
- Reset values (reset=1 at a rising edge):
  - c_valid=0, c_new_message=0, c_key=0, c_data=0, msg_count=0.
  - Key shadow=0, FIFO emptied, state=NO_MSG.
  - s_ready=1 from the first cycle after reset is released.
- Reset mid-operation: all queued and in-flight bytes are discarded and never appear on c_*.
- Input handshake:
  - Push when s_valid && s_ready.
  - s_ready = !fifo_full, registered-count based. There is no combinational path from c_ready to s_ready.
  - While full, a push is refused even if a pop happens in the same cycle.
- Output stage: a single registered slot (c_valid/c_data/c_new_message/c_key).
  - Pop condition: the FIFO is not empty and (!c_valid || c_ready).
  - On a pop, the slot loads the head entry. Otherwise, if c_ready is high, c_valid clears.
  - While c_valid && !c_ready, all c_* outputs hold stable.
  - When c_valid=0, c_data and c_key keep their last values, and c_new_message=0.
- Latency: with c_ready=1 and the FIFO empty, a byte pushed at edge N appears on c_* after edge N+1, i.e. 2-cycle first-word latency.
- Throughput: 1 byte/cycle sustained with c_ready=1.
- State machine:
  - States: NO_MSG (no message started since reset) and IN_MSG.
  - Message start condition: the popped entry has sof=1, OR the state is NO_MSG. The first byte after reset always starts a message even if s_sof=0.
  - On a message-start pop:
    - c_new_message=1 for that byte.
    - c_key <= key shadow.
    - msg_count increments, wrapping 2^CNT_W-1 -> 0.
    - State -> IN_MSG.
  - On any other pop: c_new_message=0 and c_key is unchanged.
- Key shadow:
  - key_wr=1 loads the shadow at the edge.
  - If key_wr coincides with a message-start pop, c_key takes the pre-write shadow value; the new key applies to the following message.
  - Repeated writes: the last write before the start pop wins.
- Gaps: an empty FIFO mid-message simply deasserts c_valid; the message continues when data resumes.
- Width rules: msg_count is modulo 2^CNT_W; FIFO pointers are log2(DEPTH)+1 bits, with full/empty decided by the MSB compare.
- Capacity: DEPTH bytes in the FIFO plus 1 in the output slot.

Test Plan:
- Reset: hold reset=1 for 2 cycles -> c_valid=0, c_new_message=0, c_key=00, c_data=00, msg_count=0, busy=0; s_ready=1 after release.
- Streaming: key_wr 2B, then push bytes 00..09 back-to-back with s_sof=1 on 00, c_ready=1 -> c_valid high for 10 consecutive cycles starting 2 cycles after the first push, data 00..09 in order, c_new_message=1 only with 00, c_key=2B throughout, msg_count=1.
- Key at boundary: key_wr 7E during byte 05 of a message -> c_key stays 2B until the next s_sof byte; that byte shows c_key=7E together with c_new_message=1, and msg_count=2. A key_wr 11 in the same cycle as a start pop -> c_key=7E for that message, 11 for the next one.
- Backpressure/full: c_ready=0, push 20 bytes 40..53 continuously -> exactly 17 (40..50) accepted, then s_ready=0 and c_* hold at 40. Then c_ready=1 -> 40..50 emitted in order with no loss or duplicates, and s_ready returns to 1.
- Missing sof: first byte after reset A5 pushed with s_sof=0 -> it emerges with c_new_message=1 and msg_count=1; the following non-sof bytes have c_new_message=0.
- Mid-operation reset: with 5 bytes queued and c_ready=0, assert reset for 1 cycle -> next cycle c_valid=0 and busy=0; the queued bytes never appear on c_data; msg_count=0.
